// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/WB/HALT)
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin execution from RESET_PC (IDLE or HALT only)
//   imem_req/addr/ack/rdata  instruction fetch handshake
//   ir                    instruction register for decode
//   jump/branch/is_zero/target  control-flow inputs, sampled when EXEC ends
//   stall                 holds EXEC
//   regwrite -> reg_we    write enable gated to the WB cycle
//   pc, busy, halted, instr_count  status
module core_seq #(
    parameter int             PC_W      = 16,
    parameter int             INSTR_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [2:0]     HALT_OP   = 3'b111,
    parameter int             MAX_INSTR = 0,
    parameter int             CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    input  logic               jump,
    input  logic               branch,
    input  logic               is_zero,
    input  logic [PC_W-1:0]    target,
    input  logic               stall,
    input  logic               regwrite,
    output logic               reg_we,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
    state_t state, state_nx;
    logic taken_q;
    logic [PC_W-1:0] target_q;
    logic [CNT_W-1:0] count_inc;
    logic budget_hit;
    assign count_inc  = &instr_count ? instr_count : instr_count + CNT_W'(1);
    assign budget_hit = (MAX_INSTR != 0) && (count_inc == CNT_W'(MAX_INSTR));
    assign imem_addr  = pc;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    // outputs decode from state only, so imem_req falls with the async reset
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        reg_we   = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        case (state)
            S_IDLE:   state_nx = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                state_nx = imem_ack ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                busy     = 1'b1;
                state_nx = (ir[INSTR_W-1 -: 3] == HALT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                busy     = 1'b1;
                state_nx = stall ? S_EXEC : S_WB;
            end
            S_WB: begin
                busy     = 1'b1;
                reg_we   = regwrite;
                state_nx = budget_hit ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                halted   = 1'b1;
                state_nx = start ? S_FETCH : S_HALT;
            end
            default:  state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc          <= RESET_PC;
            ir          <= '0;
            instr_count <= '0;
            taken_q     <= 1'b0;
            target_q    <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT:
                    if (start) begin
                        pc          <= RESET_PC;
                        instr_count <= '0;
                    end
                S_FETCH:
                    if (imem_ack) ir <= imem_rdata;
                // control inputs may change once EXEC ends, so keep the decision
                S_EXEC:
                    if (!stall) begin
                        taken_q  <= jump | (branch & is_zero);
                        target_q <= target;
                    end
                S_WB: begin
                    pc          <= taken_q ? target_q : pc + PC_W'(1);
                    instr_count <= count_inc;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: self-checking bench for core_seq
module tb_core_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
    logic        imem_req, imem_ack, jump, branch, is_zero, stall, regwrite, reg_we, busy, halted;
    logic [15:0] imem_addr, imem_rdata, ir, target, pc;
    logic [31:0] instr_count;
    logic        req2, we2, busy2, halted2;
    logic [15:0] addr2, ir2, pc2;
    logic [31:0] cnt2;
    logic [15:0] mem [256];
    logic [2:0]  op;
    int ack_delay = 0, stall_len = 0, wcnt = 0, since_ack = 0;
    int n_chk = 0, n_fail = 0;

    typedef struct {logic [15:0] word; int d; int s; logic [15:0] nxt; int we;} vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    // instruction memory with programmable wait states, and a bench-side decode of ir
    assign imem_rdata = mem[imem_addr[7:0]];
    assign imem_ack   = imem_req && (wcnt >= ack_delay);
    assign op         = ir[15:13];
    assign jump       = (op == 3'd1) || (op == 3'd3);
    assign branch     = (op == 3'd2) || (op == 3'd3);
    assign is_zero    = ir[12];
    assign target     = {{4{ir[11]}}, ir[11:0]};
    assign regwrite   = ir[0];
    assign stall      = (since_ack >= 2) && (since_ack < 2 + stall_len);

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wcnt      <= 0;
            since_ack <= 0;
        end else begin
            wcnt      <= (imem_req && !imem_ack) ? wcnt + 1 : 0;
            since_ack <= imem_ack ? 1 : (since_ack != 0 ? since_ack + 1 : 0);
        end

    core_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .jump(jump), .branch(branch), .is_zero(is_zero), .target(target),
        .stall(stall), .regwrite(regwrite), .reg_we(reg_we), .pc(pc),
        .busy(busy), .halted(halted), .instr_count(instr_count)
    );

    core_seq #(.MAX_INSTR(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(16'h0001),
        .ir(ir2), .jump(1'b0), .branch(1'b0), .is_zero(1'b0), .target(16'h0000),
        .stall(1'b0), .regwrite(1'b1), .reg_we(we2), .pc(pc2),
        .busy(busy2), .halted(halted2), .instr_count(cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        while (!imem_ack && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (!imem_ack) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: no imem_ack after %0d cycles", cyc);
        end
    endtask

    // from one ack cycle to the next, counting cycles and reg_we pulses
    task automatic step(output int cyc, output int we);
        cyc = 0; we = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (reg_we) we++;
        end while (!imem_ack && cyc < 60);
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    endtask

    initial begin
        int cyc, we, d, s, first;
        logic [15:0] mpc, w;
        logic [31:0] mcnt;
        logic tk;
        tbl[0] = '{16'h0001, 0, 0, 16'h0001, 1};
        tbl[1] = '{16'h0000, 0, 0, 16'h0001, 0};
        tbl[2] = '{16'h0001, 3, 0, 16'h0001, 1};
        tbl[3] = '{16'h0001, 3, 2, 16'h0001, 1};
        tbl[4] = '{16'h5040, 0, 0, 16'h0040, 0};
        tbl[5] = '{16'h4040, 0, 0, 16'h0001, 0};
        tbl[6] = '{16'h2040, 0, 0, 16'h0040, 0};
        tbl[7] = '{16'h6041, 0, 0, 16'h0041, 1};
        tbl[8] = '{16'h2FFF, 0, 0, 16'hFFFF, 1};
        tbl[9] = '{16'h4041, 1, 1, 16'h0001, 1};
        clear_mem();
        do_reset();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_cnt", instr_count, 0);
        chk("rst_flags", {imem_req, reg_we, busy, halted}, 4'b0000);
        chk("rst_dut2", {req2, busy2, halted2, cnt2}, 0);

        // single-instruction vectors; start held high while busy must be ignored
        for (int i = 0; i < 10; i++) begin
            clear_mem();
            mem[0] = tbl[i].word;
            ack_delay = tbl[i].d; stall_len = tbl[i].s;
            do_reset();
            pulse_start();
            chk("vec_req", imem_req, 1'b1);
            wait_ack(cyc);
            chk("vec_first_wait", cyc, tbl[i].d);
            chk("vec_addr0", imem_addr, 16'h0000);
            start = 1'b1;
            step(cyc, we);
            start = 1'b0;
            chk("vec_gap", cyc, 4 + tbl[i].d + tbl[i].s);
            chk("vec_next_addr", imem_addr, tbl[i].nxt);
            chk("vec_reg_we", we, tbl[i].we);
            chk("vec_count", instr_count, 1);
        end

        // three sequential nops, zero wait
        clear_mem();
        for (int a = 0; a < 4; a++) mem[a] = 16'h0001;
        ack_delay = 0; stall_len = 0;
        do_reset();
        pulse_start();
        wait_ack(cyc);
        for (int k = 1; k <= 3; k++) begin
            step(cyc, we);
            chk("seq_gap", cyc, 4);
            chk("seq_addr", imem_addr, 16'(k));
            chk("seq_we", we, 1);
        end
        chk("seq_count", instr_count, 3);

        // wait states: request and address stable until ack
        ack_delay = 3;
        do_reset();
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            chk("wait_req", {imem_req, imem_ack, imem_addr}, {2'b10, 16'h0000});
            @(negedge clk);
        end
        chk("wait_ack", imem_ack, 1'b1);

        // HALT word at address 2
        clear_mem();
        mem[0] = 16'h0001; mem[1] = 16'h0001; mem[2] = 16'hE001;
        ack_delay = 0;
        do_reset();
        pulse_start();
        wait_ack(cyc);
        step(cyc, we);
        step(cyc, we);
        chk("halt_addr", imem_addr, 16'h0002);
        @(negedge clk);
        chk("halt_decode", {halted, reg_we}, 2'b00);
        @(negedge clk);
        chk("halt_state", {halted, busy, imem_req, reg_we}, 4'b1000);
        chk("halt_count", instr_count, 2);
        chk("halt_pc", pc, 16'h0002);
        repeat (3) @(negedge clk);
        chk("halt_hold", {halted, imem_req, ir}, {2'b10, 16'hE001});
        pulse_start();
        chk("restart", {imem_req, imem_addr, instr_count}, {1'b1, 16'h0000, 32'd0});

        // instruction budget on the MAX_INSTR=3 instance
        do_reset();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 12) chk("budget_last_we", we2, 1'b1);
            if (halted2 && first == 0) first = k;
            @(negedge clk);
        end
        chk("budget_halt_cycle", first, 13);
        chk("budget_state", {cnt2, pc2, req2}, {32'd3, 16'd3, 1'b0});

        // wrap through 16'hFFFF
        clear_mem();
        mem[0] = 16'h2FFF; mem[8'hFF] = 16'h0001;
        do_reset();
        pulse_start();
        wait_ack(cyc);
        step(cyc, we);
        chk("wrap_hi", imem_addr, 16'hFFFF);
        step(cyc, we);
        chk("wrap_zero", imem_addr, 16'h0000);

        // asynchronous reset in the middle of a fetch
        clear_mem();
        mem[0] = 16'h0001;
        ack_delay = 3;
        do_reset();
        pulse_start();
        wait_ack(cyc);
        repeat (4) @(negedge clk);
        chk("pre_rst", {imem_req, pc}, {1'b1, 16'h0001});
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {imem_req, busy, pc, instr_count}, {2'b00, 16'h0000, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {imem_req, busy, halted, pc}, {3'b000, 16'h0000});

        // random programs against an instruction-level model
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
            d = $urandom_range(0, 3); s = $urandom_range(0, 2);
            ack_delay = d; stall_len = s;
            do_reset();
            pulse_start();
            wait_ack(cyc);
            chk("rnd_first_wait", cyc, d);
            mpc = 16'h0000; mcnt = 0;
            for (int i = 0; i < 12; i++) begin
                chk("rnd_addr", imem_addr, mpc);
                w = mem[mpc[7:0]];
                if (w[15:13] == 3'b111) begin
                    repeat (2) @(negedge clk);
                    chk("rnd_halt", {halted, instr_count}, {1'b1, mcnt});
                    break;
                end
                step(cyc, we);
                tk = (w[15:13] == 3'd1) || (w[15:13] == 3'd3) ||
                     (((w[15:13] == 3'd2) || (w[15:13] == 3'd3)) && w[12]);
                mpc = tk ? {{4{w[11]}}, w[11:0]} : mpc + 16'd1;
                mcnt = mcnt + 1;
                chk("rnd_gap", cyc, 4 + d + s);
                chk("rnd_we", we, int'(w[0]));
                chk("rnd_count", instr_count, mcnt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle instruction sequencer for the 16-bit CPU. It owns the program counter, fetches instructions from an instruction memory over a request/acknowledge handshake, and holds the fetched word in an instruction register for the decode, ALU and regfile datapath. It gates the regfile write enable to a single write-back cycle, resolves jumps and zero-flag branches, and halts on a HALT opcode or an optional instruction budget. This replaces the free-running testbench PC, which incremented every clock and stopped at a fixed count.

## Interface

Parameters:
- PC_W, 16, program counter and instruction address width
- INSTR_W, 16, instruction width; opcode is always ir[INSTR_W-1 -: 3]
- RESET_PC, 0, PC value after reset and on every start
- HALT_OP, 3'b111, opcode that stops execution
- MAX_INSTR, 0, number of retired instructions after which the core halts; 0 means unlimited
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin execution from RESET_PC; honoured only in IDLE or HALT
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address; equals pc
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- ir  out  INSTR_W  instruction register, feeds decode
- jump  in  1  unconditional jump, from control decode of ir
- branch  in  1  conditional branch, taken when is_zero=1
- is_zero  in  1  ALU zero flag
- target  in  PC_W  jump/branch destination
- stall  in  1  holds EXEC, e.g. for a multi-cycle ALU op
- regwrite  in  1  control's write request for the current ir
- reg_we  out  1  gated regfile write enable
- pc  out  PC_W  current program counter
- busy  out  1  high in FETCH, DECODE, EXEC, WB
- halted  out  1  high in HALT
- instr_count  out  CNT_W  retired instructions since the last start

## Operation

- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. Reset enters IDLE.
- Reset values:
  - pc = RESET_PC
  - ir = 0
  - instr_count = 0
  - imem_req = 0, reg_we = 0, busy = 0, halted = 0
- IDLE: start=1 sends the core to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack=1.
  - On ack, ir <= imem_rdata and the core goes to DECODE.
- DECODE: one cycle.
  - If ir opcode == HALT_OP, go to HALT. The HALT instruction is not counted and no write occurs.
  - Otherwise go to EXEC.
- EXEC:
  - While stall=1, stay in EXEC.
  - In the cycle with stall=0, latch taken = jump | (branch & is_zero) and latch target, then go to WB.
- WB: one cycle.
  - reg_we = regwrite, combinational. reg_we is 0 in every other state.
  - pc <= taken ? latched target : pc+1. pc+1 wraps modulo 2^PC_W.
  - instr_count <= instr_count+1, saturating at all-ones.
  - If MAX_INSTR != 0 and the new count == MAX_INSTR, go to HALT; otherwise go to FETCH.
- HALT:
  - pc, ir and instr_count hold their values.
  - start=1 loads pc = RESET_PC and instr_count = 0, then goes to FETCH.
- Boundary rules:
  - imem_ack outside FETCH is ignored.
  - start in FETCH, DECODE, EXEC or WB is ignored.
  - jump and branch both high: taken.
  - A taken jump to pc+1 is legal and indistinguishable from sequential flow.
- Reset at any point:
  - imem_req drops asynchronously, and any outstanding fetch is abandoned.
  - The core returns to IDLE with all reset values.

## Timing

- Minimum instruction time is 4 cycles (FETCH, DECODE, EXEC, WB), reached when imem_ack is asserted in the first FETCH cycle. A zero-wait combinational ack is legal.
- Each cycle of ack delay adds one cycle; each stall cycle adds one cycle.
- start sampled high in IDLE gives imem_req=1 on the next cycle.
- ir is valid from the cycle after ack until the next ack.
- The pc update is visible on imem_addr in the FETCH cycle immediately after WB.
- halted rises the cycle after the DECODE of a HALT word, or the cycle after the final WB.

## Test plan

1. **Sequential fetch, zero wait:** reset, start, ack immediate, imem returns nop words with regwrite=1.
   - imem_addr = 0,1,2, four cycles apart.
   - One reg_we pulse per instruction, in the WB cycle.
   - instr_count = 3 after three WBs.
2. **Wait states:** ack delayed 3 cycles on every fetch.
   - imem_req and imem_addr stay stable through the wait.
   - 7 cycles per instruction.
   - stall=1 for 2 cycles in EXEC extends that to 9 cycles.
3. **Branch:**
   - branch=1, is_zero=1, target=16'h0040: next imem_addr = 16'h0040.
   - Same with is_zero=0: next imem_addr = pc+1.
   - jump=1 with is_zero=0: next imem_addr = target.
4. **HALT opcode at address 2:**
   - halted=1, instr_count=2, no reg_we for the HALT word, imem_req stays 0.
   - start then refetches address 0 with instr_count=0.
5. **Instruction budget:** MAX_INSTR=3 → halted=1 the cycle after the third WB, instr_count=3, pc=3.
6. **Wrap and reset:**
   - jump to 16'hFFFF, then sequential: next fetch is 16'h0000.
   - rst_n low mid-FETCH: imem_req=0 immediately; pc=RESET_PC and the core is in IDLE after release.
